// File: rtl/i2c_eeprom_burst_sequencer.sv
// Burst sequencer that splits N-word EEPROM transfers into 4-byte I2C controller frames.
// Optional write readback verification is enabled by defining I2C_EEPROM_VERIFY_EN.
module i2c_eeprom_burst_sequencer #(
    parameter int         BUF_DEPTH   = 16,
    parameter int         TWR_CYCLES  = 500_000,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter logic [2:0] CLK_RATE    = 3'd6,
    localparam int        CW          = $clog2(BUF_DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [6:0]    i_dev_addr,
    input  logic [15:0]   i_start_addr,
    input  logic [CW-1:0] i_word_cnt,
    input  logic          i_rw,
    input  logic          i_start,
    input  logic          i_wbuf_we,
    input  logic [CW-2:0] i_wbuf_addr,
    input  logic [31:0]   i_wbuf_data,
    input  logic [CW-2:0] i_rbuf_addr,
    output logic [31:0]   o_rbuf_data,
    output logic          o_busy,
    output logic          o_done,
    output logic [1:0]    o_err,
    output logic [CW-1:0] o_words_done,
    output logic [31:0]   o_i2c_ctrl,
    output logic [6:0]    o_i2c_dev_addr,
    output logic [15:0]   o_i2c_reg_addr,
    output logic [31:0]   o_i2c_w_data,
    input  logic [31:0]   i_i2c_status,
    input  logic [31:0]   i_i2c_rd_data
);

    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    localparam int TWW = $clog2(TWR_CYCLES + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_CHECK, ST_ISSUE, ST_WAIT_START, ST_WAIT_DONE,
        ST_STORE, ST_TWR, ST_VCHK, ST_NEXT, ST_DONE, ST_ERR
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          rw;
    logic [15:0]   cur_addr;
    logic          ctrl_en;
    logic [2:0]    ctrl_op;
    logic          ctrl_clr;
    logic          finish_d;
    logic          finish_seen;
    logic [TOW-1:0] tmo_cnt;
    logic [TWW-1:0] twr_cnt;
`ifdef I2C_EEPROM_VERIFY_EN
    logic          verify_phase;
`endif

    logic [31:0]   wbuf [BUF_DEPTH];
    logic [31:0]   rbuf [BUF_DEPTH];
    logic [CW-2:0] idx;
    logic [7:0]    ctl_state;
    logic          unused_status;

    assign idx           = o_words_done[CW-2:0];
    assign ctl_state     = i_i2c_status[9:2];
    assign unused_status = ^{i_i2c_status[31:10], i_i2c_status[0]};
    assign o_i2c_ctrl    = {24'd0, ctrl_clr, CLK_RATE, ctrl_op, ctrl_en};

    // NOTE: word buffers carry no reset; their contents are only meaningful after being written.
    always_ff @(posedge i_clk) begin
        if (i_wbuf_we)
            wbuf[i_wbuf_addr] <= i_wbuf_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && state == ST_STORE)
            rbuf[idx] <= i_i2c_rd_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_rbuf_data <= '0;
        else
            o_rbuf_data <= rbuf[i_rbuf_addr];
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_err          <= 2'd0;
            o_words_done   <= '0;
            o_i2c_dev_addr <= '0;
            o_i2c_reg_addr <= '0;
            o_i2c_w_data   <= '0;
            ctrl_en        <= 1'b0;
            ctrl_op        <= 3'd0;
            ctrl_clr       <= 1'b0;
            cnt            <= '0;
            rw             <= 1'b0;
            cur_addr       <= '0;
            finish_d       <= 1'b0;
            finish_seen    <= 1'b0;
            tmo_cnt        <= '0;
            twr_cnt        <= '0;
`ifdef I2C_EEPROM_VERIFY_EN
            verify_phase   <= 1'b0;
`endif
        end else begin
            o_done   <= 1'b0;
            ctrl_clr <= 1'b0;
            finish_d <= i_i2c_status[1];
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        o_i2c_dev_addr <= i_dev_addr;
                        cur_addr       <= i_start_addr;
                        cnt            <= i_word_cnt;
                        rw             <= i_rw;
                        o_err          <= 2'd0;
                        o_words_done   <= '0;
                        o_busy         <= 1'b1;
`ifdef I2C_EEPROM_VERIFY_EN
                        verify_phase   <= 1'b0;
`endif
                        state          <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cur_addr[1:0] != 2'b00 || cnt > CW'(BUF_DEPTH)) begin
                        o_err <= 2'd3;
                        state <= ST_ERR;
                    end else if (cnt == '0) begin
                        o_done <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    ctrl_en        <= 1'b1;
                    o_i2c_reg_addr <= cur_addr;
                    tmo_cnt        <= '0;
                    finish_seen    <= 1'b0;
`ifdef I2C_EEPROM_VERIFY_EN
                    // The readback reuses the latched write word as its reference.
                    ctrl_op <= (rw || verify_phase) ? 3'd1 : 3'd0;
                    if (!verify_phase)
                        o_i2c_w_data <= wbuf[idx];
`else
                    ctrl_op      <= rw ? 3'd1 : 3'd0;
                    o_i2c_w_data <= wbuf[idx];
`endif
                    state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    tmo_cnt <= tmo_cnt + TOW'(1);
                    if (tmo_cnt == TOW'(TIMEOUT_CYC - 1)) begin
                        ctrl_en <= 1'b0;
                        o_err   <= 2'd2;
                        state   <= ST_ERR;
                    end else if (ctl_state != 8'd0) begin
                        ctrl_en <= 1'b0;
                        state   <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + TOW'(1);
                    if (tmo_cnt == TOW'(TIMEOUT_CYC - 1)) begin
                        o_err <= 2'd2;
                        state <= ST_ERR;
                    end else if (finish_seen) begin
                        if (ctl_state == 8'd0) begin
                            twr_cnt <= '0;
`ifdef I2C_EEPROM_VERIFY_EN
                            state <= rw ? ST_STORE : (verify_phase ? ST_VCHK : ST_TWR);
`else
                            state <= rw ? ST_STORE : ST_TWR;
`endif
                        end
                    end else if (i_i2c_status[1] && !finish_d) begin
                        finish_seen <= 1'b1;
                        ctrl_clr    <= 1'b1;
                    end else if (ctl_state == 8'd0) begin
                        // Controller went idle without finishing: the slave NACKed.
                        o_err <= 2'd1;
                        state <= ST_ERR;
                    end
                end
                ST_STORE: state <= ST_NEXT;
                ST_TWR: begin
                    if (twr_cnt == TWW'(TWR_CYCLES - 1)) begin
`ifdef I2C_EEPROM_VERIFY_EN
                        verify_phase <= 1'b1;
                        state        <= ST_ISSUE;
`else
                        state <= ST_NEXT;
`endif
                    end else begin
                        twr_cnt <= twr_cnt + TWW'(1);
                    end
                end
`ifdef I2C_EEPROM_VERIFY_EN
                ST_VCHK: begin
                    verify_phase <= 1'b0;
                    if (i_i2c_rd_data != o_i2c_w_data) begin
                        o_err <= 2'd3;
                        state <= ST_ERR;
                    end else begin
                        state <= ST_NEXT;
                    end
                end
`endif
                ST_NEXT: begin
                    o_words_done <= o_words_done + CW'(1);
                    cur_addr     <= cur_addr + 16'd4;
                    if (o_words_done + CW'(1) == cnt) begin
                        o_done <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ERR: begin
                    ctrl_en <= 1'b0;
                    o_done  <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_burst_sequencer.sv
// Directed bench for i2c_eeprom_burst_sequencer with a behavioural I2C controller model.
module tb_i2c_eeprom_burst_sequencer;

    localparam int BUF_DEPTH = 16;
    localparam int CW        = 5;
    localparam int TWR       = 20;
    localparam int TMO       = 300;
    localparam int FRAME     = 12;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [6:0]    i_dev_addr = '0;
    logic [15:0]   i_start_addr = '0;
    logic [CW-1:0] i_word_cnt = '0;
    logic          i_rw = 1'b0;
    logic          i_start = 1'b0;
    logic          i_wbuf_we = 1'b0;
    logic [CW-2:0] i_wbuf_addr = '0;
    logic [31:0]   i_wbuf_data = '0;
    logic [CW-2:0] i_rbuf_addr = '0;
    logic [31:0]   o_rbuf_data;
    logic          o_busy, o_done;
    logic [1:0]    o_err;
    logic [CW-1:0] o_words_done;
    logic [31:0]   o_i2c_ctrl;
    logic [6:0]    o_i2c_dev_addr;
    logic [15:0]   o_i2c_reg_addr;
    logic [31:0]   o_i2c_w_data;
    logic [31:0]   status;
    logic [31:0]   rd_data = '0;

    always #5 clk = ~clk;

    i2c_eeprom_burst_sequencer #(
        .BUF_DEPTH(BUF_DEPTH), .TWR_CYCLES(TWR), .TIMEOUT_CYC(TMO), .CLK_RATE(3'd6)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_dev_addr(i_dev_addr), .i_start_addr(i_start_addr),
        .i_word_cnt(i_word_cnt), .i_rw(i_rw), .i_start(i_start), .i_wbuf_we(i_wbuf_we),
        .i_wbuf_addr(i_wbuf_addr), .i_wbuf_data(i_wbuf_data), .i_rbuf_addr(i_rbuf_addr),
        .o_rbuf_data(o_rbuf_data), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_words_done(o_words_done), .o_i2c_ctrl(o_i2c_ctrl), .o_i2c_dev_addr(o_i2c_dev_addr),
        .o_i2c_reg_addr(o_i2c_reg_addr), .o_i2c_w_data(o_i2c_w_data),
        .i_i2c_status(status), .i_i2c_rd_data(rd_data)
    );

    // Controller model: frame of FRAME cycles, finish held until clear.
    logic        m_rst = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_fin = 1'b0;
    logic [7:0]  m_state = '0;
    int          m_left = 0;
    int          mode = 0;        // 0 normal, 1 hang, 2 corrupt readback
    int          nack_frame = -1;
    int          frame_cnt = 0;
    int          cur_frame = 0;
    logic [2:0]  cur_op = '0;
    logic [15:0] cur_addr = '0;
    logic [31:0] cur_wd = '0;
    longint      cyc = 0;
    logic [15:0] log_addr [64];
    logic [2:0]  log_op   [64];
    logic [31:0] log_wd   [64];
    longint      log_t    [64];
    logic [31:0] mem      [16384];
    bit          mem_v    [16384];

    assign status = {22'd0, m_state, m_fin, 1'b0};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_rst) begin
            m_busy  <= 1'b0;
            m_fin   <= 1'b0;
            m_state <= '0;
        end else begin
            if (o_i2c_ctrl[7]) m_fin <= 1'b0;
            if (!m_busy) begin
                if (o_i2c_ctrl[0]) begin
                    m_busy    <= 1'b1;
                    m_state   <= 8'd3;
                    m_left    <= FRAME;
                    cur_op    <= o_i2c_ctrl[3:1];
                    cur_addr  <= o_i2c_reg_addr;
                    cur_wd    <= o_i2c_w_data;
                    cur_frame <= frame_cnt;
                    log_addr[6'(frame_cnt)] <= o_i2c_reg_addr;
                    log_op[6'(frame_cnt)]   <= o_i2c_ctrl[3:1];
                    log_wd[6'(frame_cnt)]   <= o_i2c_w_data;
                    log_t[6'(frame_cnt)]    <= cyc;
                    frame_cnt <= frame_cnt + 1;
                end
            end else if (mode != 1) begin
                if (m_left > 1) begin
                    m_left <= m_left - 1;
                end else begin
                    m_busy  <= 1'b0;
                    m_state <= '0;
                    if (cur_frame != nack_frame) begin
                        m_fin <= 1'b1;
                        if (cur_op == 3'd0) begin
                            mem[cur_addr[15:2]]   <= cur_wd;
                            mem_v[cur_addr[15:2]] <= 1'b1;
                        end else if (mem_v[cur_addr[15:2]]) begin
                            rd_data <= (mode == 2) ? (mem[cur_addr[15:2]] ^ 32'h1)
                                                   : mem[cur_addr[15:2]];
                        end else begin
                            rd_data <= {cur_addr, ~cur_addr};
                        end
                    end
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wbuf_write(input logic [CW-2:0] a, input logic [31:0] d);
        @(negedge clk);
        i_wbuf_we = 1'b1; i_wbuf_addr = a; i_wbuf_data = d;
        @(negedge clk);
        i_wbuf_we = 1'b0;
    endtask

    task automatic rbuf_read(input logic [CW-2:0] a, output logic [31:0] d);
        @(negedge clk);
        i_rbuf_addr = a;
        @(negedge clk);
        d = o_rbuf_data;
    endtask

    task automatic pulse_start(input logic rw, input logic [15:0] addr, input logic [CW-1:0] n,
                               output longint t0);
        @(negedge clk);
        i_dev_addr = 7'h50; i_start_addr = addr; i_word_cnt = n; i_rw = rw; i_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic run_burst(input logic rw, input logic [15:0] addr, input logic [CW-1:0] n,
                             input int budget, output int pulses, output longint t0,
                             output longint t1);
        pulse_start(rw, addr, n, t0);
        pulses = 0;
        t1 = 0;
        for (int k = 0; k < budget; k++) begin
            if (o_done) begin
                pulses++;
                if (pulses == 1) t1 = cyc;
            end
            if (pulses > 0 && !o_busy) break;
            @(negedge clk);
        end
        repeat (4) begin
            @(negedge clk);
            if (o_done) pulses++;
        end
    endtask

    int          pulses, f0, step;
    longint      t0, t1;
    logic [31:0] rv;
    logic [15:0] a16;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_words", 32'(o_words_done), 32'd0);
        check("rst_ctrl", o_i2c_ctrl, 32'h0000_0060);
        check("rst_reg_addr", 32'(o_i2c_reg_addr), 32'd0);
        check("rst_rbuf", o_rbuf_data, 32'd0);
        i_rst = 1'b0;
        m_rst = 1'b0;

        // Two-word write burst
        wbuf_write(4'd0, 32'hA5A5_0001);
        wbuf_write(4'd1, 32'h5A5A_0002);
        f0 = frame_cnt;
`ifdef I2C_EEPROM_VERIFY_EN
        step = 2;
`else
        step = 1;
`endif
        run_burst(1'b0, 16'h0100, 5'd2, 2000, pulses, t0, t1);
        check("wr_pulses", 32'(pulses), 32'd1);
        check("wr_err", 32'(o_err), 32'd0);
        check("wr_words", 32'(o_words_done), 32'd2);
        check("wr_frames", 32'(frame_cnt - f0), 32'(2 * step));
        check("wr_addr0", 32'(log_addr[6'(f0)]), 32'h0100);
        check("wr_addr1", 32'(log_addr[6'(f0 + step)]), 32'h0104);
        check("wr_op0", 32'(log_op[6'(f0)]), 32'd0);
        check("wr_data0", log_wd[6'(f0)], 32'hA5A5_0001);
        check("wr_data1", log_wd[6'(f0 + step)], 32'h5A5A_0002);
        check("wr_twr_gap", 32'(log_t[6'(f0 + step)] - log_t[6'(f0)] >= TWR), 32'd1);
        check("wr_dev", 32'(o_i2c_dev_addr), 32'h50);

        // Four-word read burst; unwritten locations return {addr, ~addr}
        f0 = frame_cnt;
        run_burst(1'b1, 16'h0000, 5'd4, 2000, pulses, t0, t1);
        check("rd_pulses", 32'(pulses), 32'd1);
        check("rd_err", 32'(o_err), 32'd0);
        check("rd_words", 32'(o_words_done), 32'd4);
        check("rd_op", 32'(log_op[6'(f0)]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            a16 = 16'(4 * i);
            rbuf_read(4'(i), rv);
            check($sformatf("rd_rbuf%0d", i), rv, {a16, ~a16});
        end

        // NACK on the second of three words
        f0 = frame_cnt;
        nack_frame = f0 + 1;
        run_burst(1'b1, 16'h0040, 5'd3, 2000, pulses, t0, t1);
        check("nack_pulses", 32'(pulses), 32'd1);
        check("nack_err", 32'(o_err), 32'd1);
        check("nack_words", 32'(o_words_done), 32'd1);
        check("nack_frames", 32'(frame_cnt - f0), 32'd2);
        nack_frame = -1;

        // Controller never finishes
        mode = 1;
        run_burst(1'b1, 16'h0080, 5'd1, TMO + 200, pulses, t0, t1);
        check("tmo_pulses", 32'(pulses), 32'd1);
        check("tmo_err", 32'(o_err), 32'd2);
        check("tmo_enable", 32'(o_i2c_ctrl[0]), 32'd0);
        check("tmo_elapsed", 32'(t1 - t0 >= TMO), 32'd1);
        mode = 0;
        @(negedge clk); m_rst = 1'b1;
        @(negedge clk); m_rst = 1'b0;

        // Misaligned start address and oversize count
        f0 = frame_cnt;
        run_burst(1'b0, 16'h0102, 5'd1, 100, pulses, t0, t1);
        check("align_err", 32'(o_err), 32'd3);
        check("align_pulses", 32'(pulses), 32'd1);
        run_burst(1'b1, 16'h0000, 5'd17, 100, pulses, t0, t1);
        check("cnt_err", 32'(o_err), 32'd3);
        check("bad_no_frames", 32'(frame_cnt - f0), 32'd0);

        // Address wrap at top of the 16-bit space
        f0 = frame_cnt;
        run_burst(1'b1, 16'hFFFC, 5'd2, 2000, pulses, t0, t1);
        check("wrap_err", 32'(o_err), 32'd0);
        check("wrap_addr0", 32'(log_addr[6'(f0)]), 32'hFFFC);
        check("wrap_addr1", 32'(log_addr[6'(f0 + 1)]), 32'h0000);
        rbuf_read(4'd1, rv);
        check("wrap_rbuf1", rv, 32'h0000_FFFF);

        // Zero-length burst
        f0 = frame_cnt;
        run_burst(1'b1, 16'h0000, 5'd0, 100, pulses, t0, t1);
        check("zero_pulses", 32'(pulses), 32'd1);
        check("zero_latency", 32'(t1 - t0 <= 3), 32'd1);
        check("zero_frames", 32'(frame_cnt - f0), 32'd0);
        check("zero_err", 32'(o_err), 32'd0);

`ifdef I2C_EEPROM_VERIFY_EN
        // Corrupted readback
        mode = 2;
        wbuf_write(4'd0, 32'h1234_5678);
        run_burst(1'b0, 16'h0200, 5'd1, 2000, pulses, t0, t1);
        check("vfy_err", 32'(o_err), 32'd3);
        check("vfy_words", 32'(o_words_done), 32'd0);
        mode = 0;
`endif

        // Reset while waiting for the controller to finish
        pulse_start(1'b1, 16'h0300, 5'd1, t0);
        for (int k = 0; k < 50; k++) begin
            if (m_busy) break;
            @(negedge clk);
        end
        check("mid_model_busy", 32'(m_busy), 32'd1);
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_ctrl", o_i2c_ctrl, 32'h0000_0060);
        check("mid_rst_reg_addr", 32'(o_i2c_reg_addr), 32'd0);
        check("mid_rst_words", 32'(o_words_done), 32'd0);
        i_rst = 1'b0;
        repeat (FRAME + 5) @(negedge clk);
        check("mid_after_busy", 32'(o_busy), 32'd0);
        check("mid_after_done", 32'(o_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
